// File: rtl/cpu_ififo_pkg.sv
// Shared definitions for the moxie instruction FIFO: opcode length decode.
// Optional feature macro used by the core: CPU_IFIFO_ERR_EN (sticky overflow flag).
package cpu_ififo_pkg;

   localparam int unsigned SHORT_LEN = 1;
   localparam int unsigned LONG_LEN  = 3;

   // Form-1 opcode bytes that carry a 32-bit immediate in the next two halfwords.
   localparam int unsigned NUM_LONG_OPS = 18;
   localparam logic [NUM_LONG_OPS*8-1:0] LONG_OPS = {
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
      8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39
   };

   // Instruction length in halfwords for a given head halfword.
   function automatic logic [1:0] insn_len(input logic [15:0] hw);
      logic [1:0] len;
      len = 2'(SHORT_LEN);
      if (!hw[15]) begin
         for (int i = 0; i < NUM_LONG_OPS; i++) begin
            if (hw[15:8] == LONG_OPS[i*8 +: 8]) len = 2'(LONG_LEN);
         end
      end
      return len;
   endfunction

endpackage

// File: rtl/cpu_ififo_if.sv
// Fetch/decode-side signal bundle of the instruction FIFO.
// master: fetch and decode logic driving the FIFO; slave: the FIFO itself.
interface cpu_ififo_if;
   logic [31:0] data_i;
   logic        write_en_i;
   logic        read_en_i;
   logic [31:0] PC_i;
   logic        newPC_p_i;
   logic [15:0] opcode_o;
   logic [31:0] operand_o;
   logic        valid_o;
   logic        empty_o;
   logic        full_o;
   logic [31:0] PC_o;

   modport master (
      output data_i, write_en_i, read_en_i, PC_i, newPC_p_i,
      input  opcode_o, operand_o, valid_o, empty_o, full_o, PC_o
   );

   modport slave (
      input  data_i, write_en_i, read_en_i, PC_i, newPC_p_i,
      output opcode_o, operand_o, valid_o, empty_o, full_o, PC_o
   );
endinterface

// File: rtl/cpu_ififo_core.sv
// Moxie instruction FIFO: stores fetched 32-bit words as halfwords and hands
// decode one whole instruction (opcode + optional 32-bit immediate) per read.
// Optional macro CPU_IFIFO_ERR_EN adds a sticky overflow_o output.
module cpu_ififo_core
   import cpu_ififo_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   cpu_ififo_if.slave bus
`ifdef CPU_IFIFO_ERR_EN
   ,
   output logic overflow_o
`endif
);

   localparam logic [AW:0] FullThr = (AW+1)'(DEPTH - 2);

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] rp_q, wp_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   head_pc_q, head_pc_d;
   logic          valid_q;
   logic [15:0]   opcode_q;
   logic [31:0]   operand_q;
   logic [31:0]   pc_q;

   logic [1:0]    hlen;
   logic          is_long;
   logic [AW:0]   len_cnt;
   logic          full, do_wr, do_rd;

   // Decode head instruction length and decide which transfers happen this cycle.
   always_comb begin
      hlen    = insn_len(mem_q[rp_q]);
      is_long = (hlen == 2'(LONG_LEN));
      len_cnt = (AW+1)'(hlen);
      full    = (cnt_q > FullThr);
      do_wr   = bus.write_en_i && !full;
      // Uses pre-write count: a word written this cycle is not yet readable.
      do_rd   = bus.read_en_i && (cnt_q >= len_cnt);
      cnt_d   = cnt_q + (do_wr ? (AW+1)'(2) : '0) - (do_rd ? len_cnt : '0);
      head_pc_d = head_pc_q;
      if (bus.newPC_p_i) begin
         head_pc_d = bus.PC_i;
      end else if (do_rd) begin
         head_pc_d = head_pc_q + (is_long ? 32'd6 : 32'd2);
      end
   end

   // Pointers, occupancy, head PC and registered decode-side outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rp_q      <= '0;
         wp_q      <= '0;
         cnt_q     <= '0;
         head_pc_q <= '0;
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         operand_q <= '0;
         pc_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         head_pc_q <= head_pc_d;
         valid_q   <= do_rd;
         if (do_wr) wp_q <= wp_q + AW'(2);
         if (do_rd) begin
            rp_q     <= rp_q + AW'(hlen);
            opcode_q <= mem_q[rp_q];
            pc_q     <= head_pc_q;
            operand_q <= is_long ? {mem_q[rp_q + AW'(1)], mem_q[rp_q + AW'(2)]} : 32'h0;
         end
      end
   end

   // Halfword storage; [31:16] of the fetched word is the earlier halfword.
   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wp_q]           <= bus.data_i[31:16];
         mem_q[wp_q + AW'(1)] <= bus.data_i[15:0];
      end
   end

`ifdef CPU_IFIFO_ERR_EN
   logic overflow_q;

   // Sticky flag for a write attempted while full; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) overflow_q <= 1'b0;
      else if (bus.write_en_i && full) overflow_q <= 1'b1;
   end

   assign overflow_o = overflow_q;
`endif

   assign bus.opcode_o  = opcode_q;
   assign bus.operand_o = operand_q;
   assign bus.valid_o   = valid_q;
   assign bus.PC_o      = pc_q;
   assign bus.empty_o   = (cnt_q == '0);
   assign bus.full_o    = full;

endmodule

// File: tb/tb_cpu_ififo_core.sv
// Self-checking bench for cpu_ififo_core: halfword-queue reference model plus
// a scoreboard of expected instructions compared when valid_o pulses.
module tb_cpu_ififo_core;

   localparam int unsigned DEPTH = 8;

   typedef struct packed {
      logic [15:0] op;
      logic [31:0] opd;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   cpu_ififo_if bus ();
`ifdef CPU_IFIFO_ERR_EN
   logic overflow;
`endif

   cpu_ififo_core #(.DEPTH(DEPTH), .AW(3)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
`ifdef CPU_IFIFO_ERR_EN
      ,
      .overflow_o (overflow)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   logic [15:0] hq [$];
   exp_t        sb [$];
   logic [31:0] m_pc;
   exp_t        last;
   logic        m_ovf;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic int ref_len(input logic [15:0] h);
      if (h[15]) return 1;
      case (h[15:8])
         8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
         8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39: return 3;
         default: return 1;
      endcase
   endfunction

   // One clock: drive inputs, update the model, then check outputs after the edge.
   task automatic step(input logic wr, input logic [31:0] d, input logic rd,
                       input logic npc = 1'b0, input logic [31:0] pc = 32'h0);
      logic exp_valid;
      exp_t e;
      int   len;
      bus.write_en_i = wr;
      bus.data_i     = d;
      bus.read_en_i  = rd;
      bus.newPC_p_i  = npc;
      bus.PC_i       = pc;
      exp_valid = 1'b0;
      len = 1;
      if (rd && hq.size() > 0 && hq.size() >= ref_len(hq[0])) begin
         len   = ref_len(hq[0]);
         e.op  = hq[0];
         e.opd = (len == 3) ? {hq[1], hq[2]} : 32'h0;
         e.pc  = m_pc;
         for (int i = 0; i < len; i++) void'(hq.pop_front());
         sb.push_back(e);
         exp_valid = 1'b1;
      end
      if (npc) m_pc = pc;
      else if (exp_valid) m_pc = m_pc + ((len == 3) ? 32'd6 : 32'd2);
      if (wr) begin
         if (hq.size() + len * int'(exp_valid) <= DEPTH - 2 + len * int'(exp_valid)
             && hq.size() + 2 * 0 <= DEPTH) begin
         end
      end
      @(posedge clk);
      #1;
      // Write eligibility is decided on the pre-read occupancy.
      check_eq("valid", {31'b0, bus.valid_o}, {31'b0, exp_valid});
      if (bus.valid_o) begin
         if (sb.size() == 0) begin
            check_eq("sb_underrun", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            last = e;
            check_eq("opcode", {16'b0, bus.opcode_o}, {16'b0, e.op});
            check_eq("operand", bus.operand_o, e.opd);
            check_eq("pc", bus.PC_o, e.pc);
         end
      end else begin
         if (exp_valid && sb.size() > 0) void'(sb.pop_back());
         check_eq("hold_opcode", {16'b0, bus.opcode_o}, {16'b0, last.op});
         check_eq("hold_pc", bus.PC_o, last.pc);
      end
   endtask

   // Model write: tracked separately so full is judged on pre-cycle occupancy.
   task automatic wstep(input logic [31:0] d, input logic rd = 1'b0,
                        input logic npc = 1'b0, input logic [31:0] pc = 32'h0);
      int pre;
      pre = hq.size();
      step(1'b1, d, rd, npc, pc);
      if (pre <= DEPTH - 2) begin
         hq.push_back(d[31:16]);
         hq.push_back(d[15:0]);
      end else begin
         m_ovf = 1'b1;
      end
      check_eq("empty", {31'b0, bus.empty_o}, {31'b0, hq.size() == 0});
      check_eq("full", {31'b0, bus.full_o}, {31'b0, hq.size() > DEPTH - 2});
   endtask

   task automatic rstep(input logic npc = 1'b0, input logic [31:0] pc = 32'h0);
      step(1'b0, 32'h0, 1'b1, npc, pc);
      check_eq("empty", {31'b0, bus.empty_o}, {31'b0, hq.size() == 0});
      check_eq("full", {31'b0, bus.full_o}, {31'b0, hq.size() > DEPTH - 2});
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      hq.delete();
      sb.delete();
      m_pc = 32'h0;
      m_ovf = 1'b0;
      last = '0;
      check_eq("rst_valid", {31'b0, bus.valid_o}, 32'd0);
      check_eq("rst_opcode", {16'b0, bus.opcode_o}, 32'd0);
      check_eq("rst_operand", bus.operand_o, 32'd0);
      check_eq("rst_pc", bus.PC_o, 32'd0);
      check_eq("rst_empty", {31'b0, bus.empty_o}, 32'd1);
      check_eq("rst_full", {31'b0, bus.full_o}, 32'd0);
`ifdef CPU_IFIFO_ERR_EN
      check_eq("rst_ovf", {31'b0, overflow}, 32'd0);
`endif
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.data_i = '0;
      bus.write_en_i = 1'b0;
      bus.read_en_i = 1'b0;
      bus.PC_i = '0;
      bus.newPC_p_i = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Two short instructions from one word.
      wstep(32'h0412_0513, 1'b0, 1'b1, 32'h1000);
      rstep();
      rstep();
      check_eq("t1_pc_last", bus.PC_o, 32'h1002);

      // Long instruction spanning two words, then the trailing short one.
      wstep(32'h0110_DEAD);
      wstep(32'hBEEF_0000);
      rstep();
      check_eq("t2_operand", bus.operand_o, 32'hDEADBEEF);
      rstep();
      check_eq("t2_pc", bus.PC_o, 32'h100A);

      // Incomplete long instruction must not be popped.
      wstep(32'h0110_DEAD);
      rstep();
      wstep(32'hBEEF_0000);
      rstep();
      rstep();

      // Fill to full, one dropped write, drain in order.
      wstep(32'h8001_8002);
      wstep(32'h8003_8004);
      wstep(32'h8005_8006);
      wstep(32'h8007_8008);
      wstep(32'h9999_9999);
`ifdef CPU_IFIFO_ERR_EN
      check_eq("ovf", {31'b0, overflow}, {31'b0, m_ovf});
`endif
      for (int i = 0; i < 8; i++) rstep();

      // Wrap: advance pointers to 6, then a long instruction straddling the end.
      do_reset();
      wstep(32'h8101_8102);
      wstep(32'h8103_8104);
      wstep(32'h8105_8106);
      for (int i = 0; i < 6; i++) rstep();
      wstep(32'h0301_1234);
      wstep(32'h5678_9ABC);
      rstep();
      check_eq("wrap_operand", bus.operand_o, 32'h12345678);
      // Simultaneous write and read.
      wstep(32'h8201_8202, 1'b1);
      rstep();
      rstep();
      // newPC in the same cycle as a read overrides the increment.
      wstep(32'h8301_8302);
      rstep(1'b1, 32'h3000);
      rstep();
      check_eq("npc_override", bus.PC_o, 32'h3000);

      // Flush mid-stream, then restart at a new PC.
      wstep(32'h8401_8402);
      do_reset();
      wstep(32'h8501_8502, 1'b0, 1'b1, 32'h2000);
      rstep();
      check_eq("flush_pc", bus.PC_o, 32'h2000);
      rstep();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_ififo_core.md
Name: cpu_ififo_core

Overview:
- Instruction FIFO for the moxie fetch stage: decouples 32-bit instruction-memory words from variable-length moxie instructions.
- Accepts big-endian 32-bit words from the fetch unit and stores them as 16-bit halfwords.
- Hands the decode stage one complete instruction per read: a 16-bit opcode plus an optional 32-bit operand, tagged with its PC.
- Flushed by reset on every branch; the fetch unit drives that reset and newPC_p_i.

Parameters:
- DEPTH, 8, storage in halfwords; power of two, minimum 4.
- AW, 3, pointer width, log2(DEPTH).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; asynchronous, active-low (0 = reset). Used for both power-on and branch flush.
- data_i  in  32  fetched word; [31:16] is the earlier halfword.
- write_en_i  in  1  push data_i as two halfwords.
- read_en_i  in  1  request one instruction.
- PC_i  in  32  fetch PC; the address of the next word to be written.
- newPC_p_i  in  1  load the head PC from PC_i.
- opcode_o  out  16  opcode of the presented instruction.
- operand_o  out  32  immediate of a long instruction; 0 for short instructions.
- valid_o  out  1  opcode_o, operand_o and PC_o hold a new instruction this cycle.
- empty_o  out  1  halfword count == 0 (combinational).
- full_o  out  1  free space < 2 halfwords (combinational).
- PC_o  out  32  PC of the presented instruction.

Behaviour:
- Reset (async, rst_i=0):
  - Read pointer, write pointer and count cleared.
  - valid_o=0, opcode_o=0, operand_o=0, PC_o=0, head PC=0.
  - Effect is immediate; no clock needed.
- Write:
  - When write_en_i=1 and full_o=0, mem[wp]=data_i[31:16] and mem[wp+1]=data_i[15:0]; wp+=2, count+=2.
  - Write while full_o=1 is ignored; storage is unchanged.
- Length decode (package function, on head halfword h):
  - Long (3 halfwords) when h[15]=0 and h[15:8] is one of 01,03,08,09,0C,0D,1A,1B,1D,1F,20,22,24,30,36,37,38,39 (hex).
  - All other encodings are short (1 halfword), including every form-2/form-3 encoding (h[15]=1).
- Read:
  - A read is performed when read_en_i=1 and count >= needed halfwords (1 for short, 3 for long).
  - Next edge after a performed read:
    - valid_o=1; opcode_o=mem[rp]; operand_o={mem[rp+1],mem[rp+2]} for long, 0 for short.
    - PC_o=head PC.
    - rp and count decrease by the length; head PC += 2 (short) or 6 (long).
  - Latency: 1 clock, registered outputs.
  - read_en_i=1 with an incomplete instruction: valid_o=0 next cycle, nothing is popped, data outputs hold.
  - read_en_i=0: valid_o=0 next cycle, data outputs hold.
- Simultaneous write and read in one cycle:
  - Both occur; count = count + 2 - length.
  - Read eligibility uses the pre-write count; same-cycle write data is not readable.
- newPC_p_i=1 at an edge: head PC = PC_i, overriding any increment from a read in the same cycle.
- Pointers wrap modulo DEPTH; a long instruction may straddle the wrap boundary.
- count range 0..DEPTH; full_o is based on count > DEPTH-2.

Optional Feature:
- Macro: CPU_IFIFO_ERR_EN.
- When defined, adds output overflow_o (1 bit).
  - Sticky; set at the edge where write_en_i=1 while full_o=1.
  - Cleared only by reset.
- When not defined, the port is absent and overflowing writes are silently dropped.

Decomposition:
- Package cpu_ififo_pkg holds:
  - the long-opcode constant list;
  - function insn_len(halfword) returning 1 or 3;
  - constants SHORT_LEN=1, LONG_LEN=3.
- No sub-module; storage is an internal register array.

Test Plan:
- Reset then newPC_p_i=1 with PC_i=0x1000; write 0x0412_0513; read twice -> valid_o pulses carrying opcode 0x0412, PC_o 0x1000, then opcode 0x0513, PC_o 0x1002, operand_o=0 both times; empty_o=1 after.
- Write 0x0110_DEAD, then 0xBEEF_0000; read -> opcode 0x0110, operand 0xDEADBEEF, PC_o=base; next read returns opcode 0x0000 at PC base+6.
- Write only 0x0110_DEAD and read -> valid_o=0, count unchanged; write 0xBEEF_0000 and read again -> valid_o=1 with operand 0xDEADBEEF.
- Fill 4 words with DEPTH=8 -> full_o=1; a 5th write is ignored (overflow_o=1 when CPU_IFIFO_ERR_EN is defined); drain 8 short reads returning the halfwords in order.
- Wrap: push/pop until rp=6, then write a long instruction across the boundary -> operand reassembled correctly.
- Assert rst_i=0 mid-stream, then newPC_p_i=1 with PC_i=0x2000 -> empty_o=1, valid_o=0 immediately; first read after refill reports PC_o=0x2000.
